// File: rtl/instruction_encoder_pkg.sv
// rv_inst_pkg: shared RV32 instruction formats, opcodes and encoder state encoding
package rv_inst_pkg;
  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_S, FMT_RSVD} fmt_e;
  typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_e;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
endpackage

// File: rtl/instruction_encoder_if.sv
// instruction_encoder_if: field-tuple input handshake and memory write handshake
interface instruction_encoder_if #(parameter int ADDR_W = 8);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_fmt;
  logic [6:0]        opcode;
  logic [2:0]        funct3;
  logic [6:0]        funct7;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [11:0]       imm;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              mem_ack;
  modport master (
    output in_valid, in_fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );
  modport slave (
    input  in_valid, in_fmt, opcode, funct3, funct7, rd, rs1, rs2, imm, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instruction_encoder_packer.sv
// instruction_packer: combinational RV32 R/I/S field-to-word packing
module instruction_packer
  import rv_inst_pkg::*;
(
  input  fmt_e        fmt,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [11:0] imm,
  output logic [31:0] word
);
  always_comb begin
    word = (fmt == FMT_R) ? {funct7, rs2, rs1, funct3, rd, opcode} :
           (fmt == FMT_I) ? {imm, rs1, funct3, rd, opcode} :
           (fmt == FMT_S) ? {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode} : 32'h0;
  end
endmodule

// File: rtl/instruction_encoder.sv
// instruction_encoder: encodes field tuples and writes them sequentially to instruction memory
module instruction_encoder
  import rv_inst_pkg::*;
#(
  parameter int ADDR_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  instruction_encoder_if.slave  bus,
  output logic [ADDR_W:0]       count,
  output logic                  full,
  output logic                  err
);
  state_e            state, state_nx;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       word, wdata;
  logic              take, rsvd, last;
  fmt_e              fmt;
  assign fmt  = fmt_e'(bus.in_fmt);
  assign rsvd = fmt == FMT_RSVD;
  assign take = state == ACCEPT && !start && bus.in_valid;
  assign last = &addr;
  instruction_packer u_packer (
    .fmt(fmt), .opcode(bus.opcode), .funct3(bus.funct3), .funct7(bus.funct7),
    .rd(bus.rd), .rs1(bus.rs1), .rs2(bus.rs2), .imm(bus.imm), .word(word)
  );
  always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? ACCEPT : IDLE;
      ACCEPT:  state_nx = (take && !rsvd) ? WRITE : ACCEPT;
      WRITE:   state_nx = !bus.mem_ack ? WRITE : last ? DONE : ACCEPT;
      default: state_nx = start ? ACCEPT : DONE;
    endcase
  end
  always_comb begin
    bus.in_ready = state == ACCEPT;
    bus.mem_we   = state == WRITE;
    full         = state == DONE;
  end
  // start is ignored while a write is in flight
  always_ff @(posedge clk) begin
    if (rst) begin
      addr  <= '0;
      count <= '0;
      wdata <= '0;
      err   <= 1'b0;
    end else begin
      err <= take && rsvd;
      if (start && state != WRITE) begin
        addr  <= '0;
        count <= '0;
      end
      if (take && !rsvd) wdata <= word;
      if (state == WRITE && bus.mem_ack) begin
        count <= count + 1'b1;
        if (!last) addr <= addr + 1'b1;
      end
    end
  end
  assign bus.mem_addr  = addr;
  assign bus.mem_wdata = wdata;
endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

Encodes RV32 instruction fields (opcode, funct3, funct7, rd, rs1, rs2, 12-bit imm) into 32-bit instruction words and writes them sequentially into instruction memory. It is the write-side counterpart of the field parser that feeds the register file and immediate path. It is used by the test/boot loader to fill instruction memory from a field stream, with a valid/ready input handshake and a write/ack memory handshake.

## Interface
- `ADDR_W`, default 8: word-address width; memory depth is 2^ADDR_W words.
- `clk`  in  1: clock; all state changes on the rising edge.
- `rst`  in  1: reset, synchronous and active-high.
- `start`  in  1: clears address and count, then arms the loader.
- `in_valid`  in  1: field tuple valid.
- `in_ready`  out  1: encoder can accept a tuple.
- `in_fmt`  in  2: 0 = R, 1 = I, 2 = S, 3 = reserved.
- `opcode`  in  7: opcode field.
- `funct3`  in  3: funct3 field.
- `funct7`  in  7: funct7 field (R format only).
- `rd`, `rs1`, `rs2`  in  5 each: register fields.
- `imm`  in  12: immediate (I and S formats).
- `mem_we`  out  1: write request.
- `mem_addr`  out  ADDR_W: word address.
- `mem_wdata`  out  32: encoded instruction.
- `mem_ack`  in  1: memory accepted the write.
- `count`  out  ADDR_W+1: number of words written since `start`.
- `full`  out  1: memory filled.
- `err`  out  1: one-cycle pulse when a reserved format is received.

## Operation
- Encoding by format:
  - R: {funct7, rs2, rs1, funct3, rd, opcode}
  - I: {imm[11:0], rs1, funct3, rd, opcode}
  - S: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}
- No field validation and no special handling of x0.
- State machine (states IDLE, ACCEPT, WRITE, DONE):
  - IDLE: `in_ready` = 0. On `start`: addr = 0, count = 0, go to ACCEPT.
  - ACCEPT: `in_ready` = 1.
    - `start` has priority over `in_valid`: it clears addr and count, the tuple is not accepted, and the state stays ACCEPT.
    - `in_valid` with fmt 0–2: register the encoded word into `mem_wdata`, go to WRITE.
    - `in_valid` with fmt 3: the tuple is consumed, `err` = 1 on the next cycle, no write, state stays ACCEPT.
  - WRITE: `in_ready` = 0; `mem_we`, `mem_addr` and `mem_wdata` are held stable until `mem_ack`.
    - On `mem_ack`: count += 1.
    - If addr == 2^ADDR_W − 1, go to DONE and leave addr unchanged.
    - Otherwise addr += 1 and go to ACCEPT.
    - `start` is ignored in WRITE.
  - DONE: `full` = 1, `in_ready` = 0, further `in_valid` ignored. `start` clears addr and count, clears `full`, and goes to ACCEPT.
- `mem_ack` outside WRITE is ignored.

## Timing
- Reset values: state IDLE; `in_ready`, `mem_we`, `full`, `err` = 0; `mem_addr`, `mem_wdata`, `count` = 0.
- `rst` mid-write drops the pending write and returns to IDLE; memory contents are not the block's concern.
- `in_ready` is decoded from registered state only; it has no combinational path from `in_valid` or `mem_ack`.
- Tuple accepted at edge N → `mem_we` = 1 with valid addr/data from cycle N+1.
- `mem_ack` sampled high at edge M → `mem_we` = 0 and `in_ready` = 1 (unless DONE) from cycle M+1.
- Peak throughput is one word per 2 cycles, reached when `mem_ack` arrives in the first WRITE cycle.
- `count` and `mem_addr` update at the ack edge; `full` rises in the cycle after the last ack.
- `err` is high for exactly one cycle per reserved tuple; back-to-back reserved tuples give consecutive `err` cycles.

## Structure
- Shared package `rv_inst_pkg`:
  - format enum (`FMT_R`, `FMT_I`, `FMT_S`, `FMT_RSVD`)
  - opcode constants (`OP_REG` = 7'b0110011, `OP_IMM` = 7'b0010011, `OP_LOAD` = 7'b0000011, `OP_STORE` = 7'b0100011)
  - state enum
- Sub-module `instruction_packer`: purely combinational field-to-word packing. It must round-trip through the existing parser for R and I formats.
- Top level holds the FSM, address/count registers and output registers.

## Test plan
- R encode: fmt 0, funct7 0x20, rs2 3, rs1 2, funct3 0, rd 1, opcode 0x33, `mem_ack` immediate → `mem_wdata` 0x403100B3 at addr 0; `count` = 1.
- I encode: fmt 1, imm 0xFFF, rs1 5, funct3 0, rd 6, opcode 0x13 → 0xFFF28313. Field-parser output on this word: rd 6, rs1 5, imm 0xFFF.
- S encode with stalled memory: fmt 2, imm 0x123, rs2 7, rs1 8, funct3 2, opcode 0x23, `mem_ack` delayed 3 cycles → word 0x127421A3 held stable for 4 cycles, `in_ready` low throughout.
- Fill and wrap, `ADDR_W` = 2: 4 back-to-back tuples with immediate ack → addrs 0..3, `count` 4, `full` = 1. A fifth `in_valid` is ignored. `start` → addr 0, `count` 0, `full` 0.
- Reserved format: fmt 3 in ACCEPT → `err` pulses 1 cycle, `mem_we` stays 0, `count` unchanged. `start` and `in_valid` together → tuple not accepted.
- Reset mid-write: `rst` while in WRITE → next cycle all outputs at reset values; `mem_ack` afterwards has no effect.
